// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_key_tracker                                              |
// | Description : Decodes PS/2 set-2 make/break codes (E0/F0 prefixes) and     |
// |               tracks held state, press/release pulses for a key table.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h72, 8'h6B, 8'h74, 8'h75},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1111,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic [7:0]          byte_in,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                code_valid,
  output logic [7:0]          last_code,
  output logic                last_ext,
  output logic                last_break,
  output logic                timeout_err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
  // Expiry is flagged on the cycle the count would step onto TIMEOUT_CYCLES-1.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]         c_EXT_BYTE = 8'hE0;
  localparam logic [7:0]         c_BRK_BYTE = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_done;
  logic                 w_ext;
  logic                 w_brk;
  logic                 w_expire;
  logic                 w_non_key;
  logic [NUM_KEYS-1:0]  w_make_hit;
  logic [NUM_KEYS-1:0]  w_brk_hit;

  assign w_non_key = byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    w_expire    = 1'b0;
    if (byte_valid) begin
      w_cnt_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (byte_in == c_EXT_BYTE)      w_state_nxt = ST_EXT;
          else if (byte_in == c_BRK_BYTE) w_state_nxt = ST_BRK;
          else if (!w_non_key)            w_done      = 1'b1;
        end
        ST_EXT: begin
          if (byte_in == c_BRK_BYTE) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (byte_in != c_EXT_BYTE) begin
            w_state_nxt = ST_IDLE;
            w_done      = !w_non_key;
            w_ext       = 1'b1;
          end
        end
        ST_BRK: begin
          if (byte_in == c_EXT_BYTE) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (byte_in != c_BRK_BYTE) begin
            w_state_nxt = ST_IDLE;
            w_done      = !w_non_key;
            w_brk       = 1'b1;
          end
        end
        default: begin
          if (byte_in != c_EXT_BYTE && byte_in != c_BRK_BYTE) begin
            w_state_nxt = ST_IDLE;
            w_done      = !w_non_key;
            w_ext       = 1'b1;
            w_brk       = 1'b1;
          end
        end
      endcase
    end else if (r_state == ST_IDLE) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == c_CNT_LAST) begin
        w_expire    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // Every table entry is compared, so duplicate codes all follow the same key.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic w_match;
    assign w_match       = w_done && (byte_in == KEY_CODES[i*8 +: 8]) && (w_ext == KEY_EXT[i]);
    assign w_make_hit[i] = w_match && !w_brk;
    assign w_brk_hit[i]  = w_match && w_brk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      code_valid  <= 1'b0;
      last_code   <= 8'h00;
      last_ext    <= 1'b0;
      last_break  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      key_held    <= (key_held | w_make_hit) & ~w_brk_hit;
      key_press   <= w_make_hit & ~key_held;
      key_release <= w_brk_hit & key_held;
      code_valid  <= w_done;
      timeout_err <= w_expire;
      if (w_done) begin
        last_code  <= byte_in;
        last_ext   <= w_ext;
        last_break <= w_brk;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// Bench for ps2_key_tracker: directed scenarios with literal expectations plus
// random byte streams checked every cycle against a prefix-flag reference model.
module tb_ps2_key_tracker;

  localparam int T = 10;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in    = 8'h00;
  logic [3:0] key_held, key_press, key_release;
  logic       code_valid, last_ext, last_break, timeout_err;
  logic [7:0] last_code;

  int n_checks = 0;
  int n_pass   = 0;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .key_held   (key_held),
    .key_press  (key_press),
    .key_release(key_release),
    .code_valid (code_valid),
    .last_code  (last_code),
    .last_ext   (last_ext),
    .last_break (last_break),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] key_code [4] = '{8'h75, 8'h74, 8'h6B, 8'h72};
  bit         key_ext  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] nonkey   [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_nonkey(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  // Reference model: prefixes accumulate as ext/brk flags until a code byte lands.
  logic       cap_valid = 1'b0;
  logic [7:0] cap_byte  = 8'h00;
  bit         m_pfx, m_ext, m_brk;
  int         m_wait;
  logic [3:0] e_held, e_press, e_rel;
  logic       e_cv, e_ext, e_brk, e_to;
  logic [7:0] e_code;

  always @(posedge clk) begin
    cap_valid <= byte_valid && !reset;
    cap_byte  <= byte_in;
  end

  always @(negedge clk) begin
    if (reset) begin
      m_pfx = 0; m_ext = 0; m_brk = 0; m_wait = 0;
      e_held = 0; e_press = 0; e_rel = 0;
      e_cv = 0; e_ext = 0; e_brk = 0; e_to = 0; e_code = 0;
    end else begin
      e_press = 0; e_rel = 0; e_cv = 0; e_to = 0;
      if (cap_valid) begin
        m_wait = 0;
        if (cap_byte == 8'hE0) begin
          m_pfx = 1; m_ext = 1;
        end else if (cap_byte == 8'hF0) begin
          m_pfx = 1; m_brk = 1;
        end else begin
          if (!is_nonkey(cap_byte)) begin
            e_cv = 1; e_code = cap_byte; e_ext = m_ext; e_brk = m_brk;
            for (int i = 0; i < 4; i++) begin
              if (key_code[i] == cap_byte && key_ext[i] == m_ext) begin
                if (m_brk && e_held[i])   e_rel[i]   = 1'b1;
                if (!m_brk && !e_held[i]) e_press[i] = 1'b1;
                e_held[i] = !m_brk;
              end
            end
          end
          m_pfx = 0; m_ext = 0; m_brk = 0;
        end
      end else if (m_pfx) begin
        m_wait++;
        if (m_wait == T - 1) begin
          e_to = 1; m_pfx = 0; m_ext = 0; m_brk = 0; m_wait = 0;
        end
      end
    end
    check("held",        32'(key_held),    32'(e_held));
    check("press",       32'(key_press),   32'(e_press));
    check("release",     32'(key_release), 32'(e_rel));
    check("code_valid",  32'(code_valid),  32'(e_cv));
    check("last_code",   32'(last_code),   32'(e_code));
    check("last_ext",    32'(last_ext),    32'(e_ext));
    check("last_break",  32'(last_break),  32'(e_brk));
    check("timeout_err", 32'(timeout_err), 32'(e_to));
  end

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    @(posedge clk); #2;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 20)      return 8'hE0;
    else if (r < 35) return 8'hF0;
    else if (r < 75) return key_code[$urandom_range(0, 3)];
    else if (r < 85) return ($urandom_range(0, 1) == 0) ? 8'h1C : 8'h29;
    else             return nonkey[$urandom_range(0, 5)];
  endfunction

  initial begin
    int presses;
    int tos;
    int r;
    repeat (3) @(posedge clk);
    #2;
    check("rst_held",  32'(key_held),   32'h0);
    check("rst_code",  32'(last_code),  32'h0);
    check("rst_cv",    32'(code_valid), 32'h0);
    reset = 1'b0;

    send(8'hE0); send(8'h75);
    check("up_held",  32'(key_held),   32'h1);
    check("up_press", 32'(key_press),  32'h1);
    check("up_cv",    32'(code_valid), 32'h1);
    check("up_code",  32'(last_code),  32'h75);
    check("up_ext",   32'(last_ext),   32'h1);
    check("up_brk",   32'(last_break), 32'h0);
    idle(1);
    check("up_press_end", 32'(key_press),  32'h0);
    check("up_cv_end",    32'(code_valid), 32'h0);

    send(8'hE0); send(8'hF0); send(8'h75);
    check("upbrk_held", 32'(key_held),    32'h0);
    check("upbrk_rel",  32'(key_release), 32'h1);
    check("upbrk_brk",  32'(last_break),  32'h1);
    send(8'h75);
    check("plain75_cv",   32'(code_valid), 32'h1);
    check("plain75_ext",  32'(last_ext),   32'h0);
    check("plain75_held", 32'(key_held),   32'h0);

    presses = 0;
    repeat (3) begin
      send(8'hE0); send(8'h74);
      check("typ_cv",   32'(code_valid), 32'h1);
      check("typ_held", 32'(key_held),   32'h2);
      if (key_press[1]) presses++;
    end
    check("typ_press_count", 32'(presses), 32'h1);

    send(8'hE0);
    for (int k = 1; k <= T; k++) begin
      idle(1);
      check("timeout_pulse", 32'(timeout_err), (k == T - 1) ? 32'h1 : 32'h0);
    end
    send(8'h6B);
    check("post_to_cv",   32'(code_valid), 32'h1);
    check("post_to_ext",  32'(last_ext),   32'h0);
    check("post_to_held", 32'(key_held),   32'h2);

    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
    check("upleft_held", 32'(key_held), 32'h5);
    send(8'hE0);
    reset = 1'b1;
    #1;
    check("midrst_held", 32'(key_held),   32'h0);
    check("midrst_code", 32'(last_code),  32'h0);
    check("midrst_ext",  32'(last_ext),   32'h0);
    check("midrst_brk",  32'(last_break), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    send(8'hF0); send(8'h6B);
    check("rstbrk_cv",   32'(code_valid),  32'h1);
    check("rstbrk_brk",  32'(last_break),  32'h1);
    check("rstbrk_ext",  32'(last_ext),    32'h0);
    check("rstbrk_rel",  32'(key_release), 32'h0);
    check("rstbrk_held", 32'(key_held),    32'h0);

    send(8'hF0); send(8'hAA);
    check("abort_cv", 32'(code_valid),  32'h0);
    check("abort_to", 32'(timeout_err), 32'h0);
    tos = 0;
    repeat (12) begin idle(1); tos += int'(timeout_err); end
    check("abort_no_to", 32'(tos), 32'h0);
    send(8'hE0); send(8'h72);
    check("down_held", 32'(key_held), 32'h8);

    for (int n = 0; n < 2500; n++) begin
      send(pick());
      r = $urandom_range(0, 99);
      if (r < 65)      idle($urandom_range(0, 2));
      else if (r < 90) idle($urandom_range(3, 8));
      else             idle($urandom_range(8, 12));
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
